// File: rtl/prime_stream.sv
// Sieve of Eratosthenes over a single-port composite bitmap, streaming primes <= limit in ascending order.
// Latency: limit+4 cycles minimum to first beat; backpressure: a beat holds in EMIT until m_ready, one beat per 2 cycles max.
module prime_stream #(
    parameter int W     = 8,
    parameter int N_MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] limit,
    output logic         busy,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         done,
    output logic [W-1:0] count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_OUTER = 3'd2;
    localparam logic [2:0] S_INNER = 3'd3;
    localparam logic [2:0] S_SCAN  = 3'd4;
    localparam logic [2:0] S_EMIT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]     state_q, state_d;
    logic [W-1:0]   limit_q, limit_d;
    logic [W:0]     i_q, i_d;
    logic [W:0]     j_q, j_d;
    logic [W:0]     k_q, k_d;
    logic [W-1:0]   m_data_q, m_data_d;
    logic [W-1:0]   count_q, count_d;

    logic           comp_q [0:N_MAX];
    logic           wr_en;
    logic [W-1:0]   wr_addr;
    logic           wr_val;
    logic [W-1:0]   rd_addr;
    logic           comp_rd;

    logic [W:0]     limit_ext;
    logic [2*W+1:0] sq;
    logic [W:0]     j_next;

    assign limit_ext = {1'b0, limit_q};
    assign sq        = i_q * i_q;
    assign j_next    = j_q + i_q;

    // OUTER reads comp[i], SCAN reads comp[k]; both only when the index is <= limit
    assign rd_addr = (state_q == S_OUTER) ? i_q[W-1:0] : k_q[W-1:0];
    assign comp_rd = comp_q[rd_addr];

    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        m_data_d = m_data_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        wr_addr  = k_q[W-1:0];
        wr_val   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    limit_d = limit;
                    count_d = '0;
                    k_d     = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                // k doubles as the clear index here; SCAN re-seeds it to 2
                wr_en   = 1'b1;
                wr_addr = k_q[W-1:0];
                wr_val  = 1'b0;
                if (k_q == limit_ext) begin
                    i_d     = (W+1)'(2);
                    state_d = S_OUTER;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_OUTER: begin
                if (sq > {{(W+2){1'b0}}, limit_q}) begin
                    k_d     = (W+1)'(2);
                    state_d = S_SCAN;
                end else if (comp_rd) begin
                    i_d = i_q + 1'b1;
                end else begin
                    j_d     = sq[W:0];
                    state_d = S_INNER;
                end
            end
            S_INNER: begin
                wr_en   = 1'b1;
                wr_addr = j_q[W-1:0];
                wr_val  = 1'b1;
                if (j_next > limit_ext) begin
                    i_d     = i_q + 1'b1;
                    state_d = S_OUTER;
                end else begin
                    j_d = j_next;
                end
            end
            S_SCAN: begin
                if (k_q > limit_ext) begin
                    state_d = S_DONE;
                end else if (!comp_rd) begin
                    m_data_d = k_q[W-1:0];
                    state_d  = S_EMIT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (m_ready) begin
                    count_d = count_q + 1'b1;
                    k_d     = k_q + 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            limit_q  <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            m_data_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            limit_q  <= limit_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            m_data_q <= m_data_d;
            count_q  <= count_d;
        end
    end

    // Bitmap is deliberately left out of reset; INIT clears the span a run uses
    always_ff @(posedge clk) begin
        if (wr_en) comp_q[wr_addr] <= wr_val;
    end

    assign busy    = (state_q != S_IDLE);
    assign m_valid = (state_q == S_EMIT);
    assign done    = (state_q == S_DONE);
    assign m_data  = m_data_q;
    assign count   = count_q;

endmodule
